// File: rtl/shift_pipe_if.sv
// Valid/ready bus of the pipelined barrel shifter: operand beat in, result beat out.
// The master side drives operands and out_ready; the slave side is the shifter.
interface shift_pipe_if #(
   parameter int WIDTH = 32
) ();
   localparam int SHAMT_W = $clog2(WIDTH);

   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   num;
   logic [SHAMT_W-1:0] shifts;
   logic [1:0]         mode;
   logic               c_in;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   shifted;
   logic               c_out;
   logic               zero;

   modport master (
      output in_valid, num, shifts, mode, c_in, out_ready,
      input  in_ready, out_valid, shifted, c_out, zero
   );

   modport slave (
      input  in_valid, num, shifts, mode, c_in, out_ready,
      output in_ready, out_valid, shifted, c_out, zero
   );
endinterface

// File: rtl/shift_pipe.sv
// Pipelined LSL/LSR/ASR/ROR barrel shifter with carry-out and zero flag.
// Stage k shifts by 2^k when its shift bit is set; one global stall freezes every stage.
module shift_pipe #(
   parameter int WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst,
   shift_pipe_if.slave bus
);
   localparam int SHAMT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      LSL = 2'b00,
      LSR = 2'b01,
      ASR = 2'b10,
      ROR = 2'b11
   } mode_e;

   // Index k is the input of stage k; index SHAMT_W is the output of the last stage.
   logic [SHAMT_W:0]   st_valid;
   logic [SHAMT_W:0]   st_carry;
   logic [WIDTH-1:0]   st_data  [SHAMT_W+1];
   logic [SHAMT_W-1:0] st_shamt [SHAMT_W+1];
   mode_e              st_mode  [SHAMT_W+1];

   logic               stall;
   logic [WIDTH-1:0]   last_data_d;
   logic               zero_q;

   assign st_valid[0] = bus.in_valid;
   assign st_data[0]  = bus.num;
   assign st_shamt[0] = bus.shifts;
   assign st_mode[0]  = mode_e'(bus.mode);
   assign st_carry[0] = bus.c_in;

   assign stall = st_valid[SHAMT_W] && !bus.out_ready;

   for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
      localparam int AMT = 1 << k;

      logic               valid_q;
      logic [WIDTH-1:0]   data_q, data_d;
      logic [SHAMT_W-1:0] shamt_q, shamt_d;
      mode_e              mode_q;
      logic               carry_q, carry_d;

      always_comb begin
         // NOTE: defaults come first so every path assigns data_d/carry_d and no latch is inferred.
         data_d  = st_data[k];
         carry_d = st_carry[k];
         shamt_d = st_shamt[k] >> 1;
         if (st_shamt[k][0]) begin
            unique case (st_mode[k])
               LSL: begin
                  data_d  = st_data[k] << AMT;
                  carry_d = st_data[k][WIDTH-AMT];
               end
               LSR: begin
                  data_d  = st_data[k] >> AMT;
                  carry_d = st_data[k][AMT-1];
               end
               ASR: begin
                  data_d  = $signed(st_data[k]) >>> AMT;
                  carry_d = st_data[k][AMT-1];
               end
               ROR: begin
                  data_d  = {st_data[k][AMT-1:0], st_data[k][WIDTH-1:AMT]};
                  carry_d = st_data[k][AMT-1];
               end
            endcase
         end
      end

      // Payload only loads with a valid beat, so bubbles never disturb the presented result.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            // NOTE: payload registers are reset as well, because shifted must read 0 (not X) after reset.
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            mode_q  <= LSL;
            carry_q <= 1'b0;
         end else if (!stall) begin
            // NOTE: non-blocking assignment, so each stage captures its predecessor's pre-edge value.
            valid_q <= st_valid[k];
            if (st_valid[k]) begin
               data_q  <= data_d;
               shamt_q <= shamt_d;
               mode_q  <= st_mode[k];
               carry_q <= carry_d;
            end
         end
      end

      assign st_valid[k+1] = valid_q;
      assign st_data[k+1]  = data_q;
      assign st_shamt[k+1] = shamt_q;
      assign st_mode[k+1]  = mode_q;
      assign st_carry[k+1] = carry_q;

      if (k == SHAMT_W - 1) begin : g_last
         assign last_data_d = data_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_q <= 1'b0;
      end else if (!stall && st_valid[SHAMT_W-1]) begin
         zero_q <= (last_data_d == '0);
      end
   end

   assign bus.in_ready  = !stall;
   assign bus.out_valid = st_valid[SHAMT_W];
   assign bus.shifted   = st_data[SHAMT_W];
   assign bus.c_out     = st_carry[SHAMT_W];
   assign bus.zero      = zero_q;
endmodule
